// File: rtl/counter_days_if.sv
// Bus between the Millennium Clock calendar chain and the day-of-month counter.
// Master drives tick/mode/month context; slave returns BCD day and the month tick.
interface counter_days_if;
  logic       mode_day;
  logic       up;
  logic       down;
  logic       tick_day;
  logic [3:0] month_unit;
  logic [3:0] month_ten;
  logic       leap_year;
  logic [3:0] day_unit;
  logic [3:0] day_ten;
  logic       tick_month;

  modport master (
    output mode_day, up, down, tick_day, month_unit, month_ten, leap_year,
    input  day_unit, day_ten, tick_month
  );

  modport slave (
    input  mode_day, up, down, tick_day, month_unit, month_ten, leap_year,
    output day_unit, day_ten, tick_month
  );
endinterface

// File: rtl/counter_days.sv
// Day-of-month counter: run mode counts daily ticks and pulses tick_month on wrap,
// set mode steps up/down; day is clamped to the current month length on every edge.
module counter_days #(
  parameter int unsigned RESET_DAY = 1
) (
  input logic           clk,
  input logic           rst,
  counter_days_if.slave bus
);

  localparam int unsigned DAY_W = 5;
  localparam logic [DAY_W-1:0] RESET_BIN  = DAY_W'(RESET_DAY);
  localparam logic [3:0]       RESET_TEN  = 4'(RESET_DAY / 10);
  localparam logic [3:0]       RESET_UNIT = 4'(RESET_DAY % 10);

  logic [DAY_W-1:0] day;
  logic [DAY_W-1:0] max_day;
  logic [DAY_W-1:0] eff_day;
  logic [DAY_W-1:0] next_day;
  logic [3:0]       next_ten;
  logic [3:0]       next_unit;
  logic             next_tick;

  // Month length; any non-BCD or out-of-range month falls to the default of 31.
  always_comb begin
    max_day = 5'd31;
    case ({bus.month_ten, bus.month_unit})
      8'h04, 8'h06, 8'h09, 8'h11: max_day = 5'd30;
      8'h02:                      max_day = bus.leap_year ? 5'd29 : 5'd28;
      default:                    max_day = 5'd31;
    endcase
  end

  // Next day, month tick and BCD split, all starting from the clamped day.
  always_comb begin
    eff_day   = (day > max_day) ? max_day : day;
    next_day  = eff_day;
    next_tick = 1'b0;
    next_ten  = 4'd0;
    next_unit = 4'd0;

    if (bus.mode_day) begin
      if (bus.tick_day) begin
        if (eff_day == max_day) begin
          next_day  = 5'd1;
          next_tick = 1'b1;
        end else begin
          next_day = DAY_W'(eff_day + 5'd1);
        end
      end
    end else if (bus.up && !bus.down) begin
      next_day = (eff_day == max_day) ? 5'd1 : DAY_W'(eff_day + 5'd1);
    end else if (bus.down && !bus.up) begin
      next_day = (eff_day == 5'd1) ? max_day : DAY_W'(eff_day - 5'd1);
    end

    if (next_day >= 5'd30) begin
      next_ten  = 4'd3;
      next_unit = 4'(next_day - 5'd30);
    end else if (next_day >= 5'd20) begin
      next_ten  = 4'd2;
      next_unit = 4'(next_day - 5'd20);
    end else if (next_day >= 5'd10) begin
      next_ten  = 4'd1;
      next_unit = 4'(next_day - 5'd10);
    end else begin
      next_ten  = 4'd0;
      next_unit = 4'(next_day);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day            <= RESET_BIN;
      bus.day_ten    <= RESET_TEN;
      bus.day_unit   <= RESET_UNIT;
      bus.tick_month <= 1'b0;
    end else begin
      day            <= next_day;
      bus.day_ten    <= next_ten;
      bus.day_unit   <= next_unit;
      bus.tick_month <= next_tick;
    end
  end

endmodule

// File: tb/tb_counter_days.sv
// Directed self-checking bench for counter_days: reset, run-mode wraps,
// February/leap handling, set mode, clamping and asynchronous reset.
module tb_counter_days;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  counter_days_if bus ();

  counter_days #(.RESET_DAY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int day_val();
    return int'(bus.day_ten) * 10 + int'(bus.day_unit);
  endfunction

  task automatic check_day(input string tag, input int exp_day, input int exp_tick);
    check({tag, "_day"}, day_val(), exp_day);
    check({tag, "_tick"}, int'(bus.tick_month), exp_tick);
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    bus.tick_day = 1'b1;
    repeat (n) clk_step();
    bus.tick_day = 1'b0;
  endtask

  task automatic set_month(input logic [3:0] ten, input logic [3:0] unit, input logic leap);
    bus.month_ten  = ten;
    bus.month_unit = unit;
    bus.leap_year  = leap;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.mode_day = 1'b1;
    bus.up       = 1'b0;
    bus.down     = 1'b0;
    bus.tick_day = 1'b1;
    set_month(4'd0, 4'd1, 1'b0);

    // Reset held 25 ns with tick_day high: day stays 01
    #2 rst = 1'b1;
    #1 check_day("rst_async", 1, 0);
    repeat (3) begin
      clk_step();
      check_day("rst_hold", 1, 0);
    end
    #1 rst = 1'b0;
    clk_step();
    check_day("rst_release", 2, 0);

    // January, tick held: 03..31 then wrap to 01 with one pulse
    for (int d = 3; d <= 31; d++) begin
      clk_step();
      check_day("jan_count", d, 0);
      check("jan_unit_bcd", int'(bus.day_unit <= 4'd9), 1);
    end
    clk_step();
    check_day("jan_wrap", 1, 1);
    bus.tick_day = 1'b0;
    clk_step();
    check_day("jan_after_wrap", 1, 0);

    // February non-leap: 28 wraps to 01
    tick_n(27);
    check_day("feb_reach28", 28, 0);
    set_month(4'd0, 4'd2, 1'b0);
    tick_n(1);
    check_day("feb_wrap", 1, 1);
    clk_step();
    check_day("feb_pulse_end", 1, 0);

    // February leap: 28 -> 29 without pulse, 29 -> 01 with pulse
    set_month(4'd0, 4'd2, 1'b1);
    tick_n(27);
    check_day("leap_reach28", 28, 0);
    tick_n(1);
    check_day("leap_29", 29, 0);
    tick_n(1);
    check_day("leap_wrap", 1, 1);

    // Set mode, April
    bus.mode_day = 1'b0;
    set_month(4'd0, 4'd4, 1'b0);
    bus.tick_day = 1'b1;
    bus.up = 1'b1;
    bus.down = 1'b1;
    repeat (20) clk_step();
    check_day("set_both", 1, 0);
    bus.down = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      clk_step();
      check_day("set_up", (i % 30) + 1, 0);
    end
    bus.up = 1'b0;
    bus.down = 1'b1;
    clk_step();
    check_day("set_down_wrap", 30, 0);
    clk_step();
    check_day("set_down", 29, 0);
    bus.down = 1'b0;
    bus.tick_day = 1'b0;

    // Reach 31 in January, then clamp in run mode with tick_day low
    set_month(4'd0, 4'd1, 1'b0);
    bus.up = 1'b1;
    repeat (2) clk_step();
    bus.up = 1'b0;
    check_day("set_to31", 31, 0);
    bus.mode_day = 1'b1;
    clk_step();
    check_day("run_idle31", 31, 0);
    set_month(4'd0, 4'd4, 1'b0);
    #1 check_day("clamp_stale", 31, 0);
    clk_step();
    check_day("clamp_apr", 30, 0);
    set_month(4'd0, 4'd2, 1'b0);
    clk_step();
    check_day("clamp_feb", 28, 0);

    // Invalid month 13 behaves as a 31-day month
    set_month(4'd1, 4'd3, 1'b0);
    tick_n(3);
    check_day("inv_31", 31, 0);
    tick_n(1);
    check_day("inv_wrap", 1, 1);

    // Asynchronous reset mid-count at day 15
    set_month(4'd0, 4'd1, 1'b0);
    tick_n(14);
    check_day("pre_rst15", 15, 0);
    bus.tick_day = 1'b1;
    #2 rst = 1'b1;
    #1 check_day("rst_mid", 1, 0);
    clk_step();
    check_day("rst_mid_hold", 1, 0);
    rst = 1'b0;
    bus.tick_day = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
